// File: rtl/cfg_regfile_multi.sv
// cfg_regfile_multi
//
// Configuration register file for the depth pipeline. It holds per-camera 3x3
// bilinear matrices, per-scale DfDD constants (A, B, W0, W1, W2), pre- and
// post-xform ROI corners and the confidence minimum. Host writes land in a
// shadow copy. A commit command arms a frame-synchronous copy into the active
// set, so the datapath never sees a half-updated configuration.
//
// Optional build macro: CFG_READBACK_EN
//   defined   : host reads return the shadow value (or commit/error status at
//               0xF0) two cycles after acceptance.
//   undefined : no read mux; rsp_* are tied to 0. Read commands are ignored
//               and never raise err_o.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   cmd_valid_i/write_i     host command strobe and direction (1 = write)
//   cmd_addr_i, cmd_data_i  register address and write data
//   frame_start_i           one-cycle frame boundary pulse
//   rsp_valid_o, rsp_data_o read response (zero-extended)
//   a_o..w2_o               active DfDD constants, one 16-bit entry per scale
//   bilinear_matrices_o     active matrices, indexed [camera][row][col]
//   pre/post_roi_boundaries_o  {top, bottom, left, right}; top is entry [3]
//   confidence_o            active confidence minimum
//   commit_pending_o        commit armed, waiting for frame_start_i
//   err_o                   sticky unmapped-address flag, cleared via 0xF1
//
// Active values reach the outputs one cycle after the commit edge. ROI
// boundaries are derived from the output-stage corners and lag one more cycle.
module cfg_regfile_multi #(
    parameter int          NUM_CAMERAS        = 2,
    parameter int          NUM_SCALES         = 3,
    parameter int          MATRIX_WIDTH       = 11,
    parameter int          ADDR_WIDTH         = 16,
    parameter int          DATA_WIDTH         = 32,
    parameter int unsigned PRE_ROI_DIMS [2]   = '{480, 512},
    parameter int unsigned POST_ROI_DIMS [2]  = '{480, 512},
    parameter logic [15:0] DEFAULT_CONST      = 16'h3c00,
    parameter logic [15:0] DEFAULT_CONFIDENCE = 16'h0000
) (
    input  logic                                                  clk_i,
    input  logic                                                  rst_i,
    input  logic                                                  cmd_valid_i,
    input  logic                                                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]                                 cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]                                 cmd_data_i,
    input  logic                                                  frame_start_i,
    output logic                                                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0]                                 rsp_data_o,
    output logic [NUM_SCALES-1:0][15:0]                           a_o,
    output logic [NUM_SCALES-1:0][15:0]                           b_o,
    output logic [NUM_SCALES-1:0][15:0]                           w0_o,
    output logic [NUM_SCALES-1:0][15:0]                           w1_o,
    output logic [NUM_SCALES-1:0][15:0]                           w2_o,
    output logic [NUM_CAMERAS-1:0][2:0][2:0][MATRIX_WIDTH-1:0]    bilinear_matrices_o,
    output logic [3:0][15:0]                                      pre_roi_boundaries_o,
    output logic [3:0][15:0]                                      post_roi_boundaries_o,
    output logic [15:0]                                           confidence_o,
    output logic                                                  commit_pending_o,
    output logic                                                  err_o
);

    typedef logic [MATRIX_WIDTH-1:0] coef_t;

`ifdef CFG_READBACK_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif

    // Boundaries as produced from all-zero corners.
    localparam logic [3:0][15:0] PRE_BND_RST  = {16'd0, 16'(PRE_ROI_DIMS[0]),  16'd0, 16'(PRE_ROI_DIMS[1])};
    localparam logic [3:0][15:0] POST_BND_RST = {16'd0, 16'(POST_ROI_DIMS[0]), 16'd0, 16'(POST_ROI_DIMS[1])};

    // Identity with 8 fractional bits: diagonal elements k = 0, 4, 8.
    function automatic coef_t ident_coef(input int k);
        return (k % 4 == 0) ? coef_t'(256) : '0;
    endfunction

    // Registered command stage
    logic                  cmd_valid_q, cmd_valid_d;
    logic                  cmd_write_q, cmd_write_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q,  cmd_addr_d;
    logic [DATA_WIDTH-1:0] cmd_data_q,  cmd_data_d;

    // Three copies of each field: shadow (host side), active (committed),
    // output stage. Constants are indexed [A,B,W0,W1,W2][scale]; ROI corners
    // are [pre_y, pre_x, post_y, post_x].
    coef_t       mat_sh_q  [NUM_CAMERAS][9], mat_sh_d  [NUM_CAMERAS][9];
    coef_t       mat_act_q [NUM_CAMERAS][9], mat_act_d [NUM_CAMERAS][9];
    coef_t       mat_out_q [NUM_CAMERAS][9], mat_out_d [NUM_CAMERAS][9];
    logic [15:0] cst_sh_q  [5][NUM_SCALES],  cst_sh_d  [5][NUM_SCALES];
    logic [15:0] cst_act_q [5][NUM_SCALES],  cst_act_d [5][NUM_SCALES];
    logic [15:0] cst_out_q [5][NUM_SCALES],  cst_out_d [5][NUM_SCALES];
    logic [15:0] conf_sh_q, conf_sh_d, conf_act_q, conf_act_d, conf_out_q, conf_out_d;
    logic [15:0] roi_sh_q  [4], roi_sh_d  [4];
    logic [15:0] roi_act_q [4], roi_act_d [4];
    logic [15:0] roi_out_q [4], roi_out_d [4];
    logic [3:0][15:0] pre_bnd_q, pre_bnd_d, post_bnd_q, post_bnd_d;
    logic        pending_q, pending_d;
    logic        err_q, err_d;

    // Address decode of the registered command
    logic [7:0] addr_lo;
    logic [3:0] grp, idx;
    logic       hi_zero, is_mat, is_cst, is_conf, is_roi, is_commit, is_clr, mapped;
    logic       wr_en, do_commit;

    // Write-data bits above the widest field are never stored.
    logic unused_data;
    assign unused_data = ^cmd_data_q[DATA_WIDTH-1:16];

    always_comb begin
        addr_lo   = cmd_addr_q[7:0];
        grp       = addr_lo[7:4];
        idx       = addr_lo[3:0];
        hi_zero   = (cmd_addr_q >> 8) == '0;
        is_mat    = hi_zero && grp >= 4'd1 && grp <= 4'(NUM_CAMERAS) && idx < 4'd9;
        is_cst    = hi_zero && grp >= 4'hA && grp <= 4'hE && idx < 4'(NUM_SCALES);
        is_conf   = hi_zero && addr_lo == 8'h50;
        is_roi    = hi_zero && addr_lo[7:2] == 6'b10_0000;
        is_commit = hi_zero && addr_lo == 8'hF0;
        is_clr    = hi_zero && addr_lo == 8'hF1;
        mapped    = is_mat || is_cst || is_conf || is_roi || is_commit || is_clr;
        wr_en     = cmd_valid_q && cmd_write_q;
        do_commit = frame_start_i && pending_q;
    end

    always_comb begin
        cmd_valid_d = cmd_valid_i;
        cmd_write_d = cmd_write_i;
        cmd_addr_d  = cmd_addr_i;
        cmd_data_d  = cmd_data_i;

        // Shadow writes, truncated to the field width
        mat_sh_d  = mat_sh_q;
        cst_sh_d  = cst_sh_q;
        conf_sh_d = conf_sh_q;
        roi_sh_d  = roi_sh_q;
        for (int c = 0; c < NUM_CAMERAS; c++)
            for (int k = 0; k < 9; k++)
                if (wr_en && is_mat && int'(grp) == c + 1 && int'(idx) == k)
                    mat_sh_d[c][k] = cmd_data_q[MATRIX_WIDTH-1:0];
        for (int g = 0; g < 5; g++)
            for (int s = 0; s < NUM_SCALES; s++)
                if (wr_en && is_cst && int'(grp) == g + 10 && int'(idx) == s)
                    cst_sh_d[g][s] = cmd_data_q[15:0];
        if (wr_en && is_conf)
            conf_sh_d = cmd_data_q[15:0];
        for (int r = 0; r < 4; r++)
            if (wr_en && is_roi && int'(addr_lo[1:0]) == r)
                roi_sh_d[r] = cmd_data_q[15:0];

        // Commit copies the pre-write shadow; a write landing on the same
        // edge stays staged for the next commit.
        mat_act_d  = mat_act_q;
        cst_act_d  = cst_act_q;
        conf_act_d = conf_act_q;
        roi_act_d  = roi_act_q;
        if (do_commit) begin
            mat_act_d  = mat_sh_q;
            cst_act_d  = cst_sh_q;
            conf_act_d = conf_sh_q;
            roi_act_d  = roi_sh_q;
        end

        mat_out_d  = mat_act_q;
        cst_out_d  = cst_act_q;
        conf_out_d = conf_act_q;
        roi_out_d  = roi_act_q;

        // 16-bit adds wrap modulo 2^16 by construction.
        pre_bnd_d  = {roi_out_q[0], roi_out_q[0] + 16'(PRE_ROI_DIMS[0]),
                      roi_out_q[1], roi_out_q[1] + 16'(PRE_ROI_DIMS[1])};
        post_bnd_d = {roi_out_q[2], roi_out_q[2] + 16'(POST_ROI_DIMS[0]),
                      roi_out_q[3], roi_out_q[3] + 16'(POST_ROI_DIMS[1])};

        // A new arm beats a simultaneous apply, so it waits for the next frame.
        pending_d = pending_q;
        if (do_commit)
            pending_d = 1'b0;
        if (wr_en && is_commit)
            pending_d = 1'b1;

        // Set beats clear.
        err_d = err_q;
        if (wr_en && is_clr)
            err_d = 1'b0;
        if (cmd_valid_q && !mapped && (cmd_write_q || READ_EN))
            err_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmd_valid_q <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            for (int c = 0; c < NUM_CAMERAS; c++)
                for (int k = 0; k < 9; k++) begin
                    mat_sh_q[c][k]  <= ident_coef(k);
                    mat_act_q[c][k] <= ident_coef(k);
                    mat_out_q[c][k] <= ident_coef(k);
                end
            for (int g = 0; g < 5; g++)
                for (int s = 0; s < NUM_SCALES; s++) begin
                    cst_sh_q[g][s]  <= DEFAULT_CONST;
                    cst_act_q[g][s] <= DEFAULT_CONST;
                    cst_out_q[g][s] <= DEFAULT_CONST;
                end
            conf_sh_q  <= DEFAULT_CONFIDENCE;
            conf_act_q <= DEFAULT_CONFIDENCE;
            conf_out_q <= DEFAULT_CONFIDENCE;
            for (int r = 0; r < 4; r++) begin
                roi_sh_q[r]  <= '0;
                roi_act_q[r] <= '0;
                roi_out_q[r] <= '0;
            end
            pre_bnd_q  <= PRE_BND_RST;
            post_bnd_q <= POST_BND_RST;
            pending_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cmd_valid_q <= cmd_valid_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            mat_sh_q    <= mat_sh_d;
            mat_act_q   <= mat_act_d;
            mat_out_q   <= mat_out_d;
            cst_sh_q    <= cst_sh_d;
            cst_act_q   <= cst_act_d;
            cst_out_q   <= cst_out_d;
            conf_sh_q   <= conf_sh_d;
            conf_act_q  <= conf_act_d;
            conf_out_q  <= conf_out_d;
            roi_sh_q    <= roi_sh_d;
            roi_act_q   <= roi_act_d;
            roi_out_q   <= roi_out_d;
            pre_bnd_q   <= pre_bnd_d;
            post_bnd_q  <= post_bnd_d;
            pending_q   <= pending_d;
            err_q       <= err_d;
        end
    end

`ifdef CFG_READBACK_EN
    // Two-stage read path: mux into rd_*, then the response register.
    logic                  rd_valid_q, rd_valid_d, rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d, rsp_data_q, rsp_data_d, rd_word;

    always_comb begin
        rd_word = '0;
        for (int c = 0; c < NUM_CAMERAS; c++)
            for (int k = 0; k < 9; k++)
                if (is_mat && int'(grp) == c + 1 && int'(idx) == k)
                    rd_word = DATA_WIDTH'(mat_sh_q[c][k]);
        for (int g = 0; g < 5; g++)
            for (int s = 0; s < NUM_SCALES; s++)
                if (is_cst && int'(grp) == g + 10 && int'(idx) == s)
                    rd_word = DATA_WIDTH'(cst_sh_q[g][s]);
        if (is_conf)
            rd_word = DATA_WIDTH'(conf_sh_q);
        for (int r = 0; r < 4; r++)
            if (is_roi && int'(addr_lo[1:0]) == r)
                rd_word = DATA_WIDTH'(roi_sh_q[r]);
        if (is_commit)
            rd_word = DATA_WIDTH'({err_q, pending_q});

        rd_valid_d  = cmd_valid_q && !cmd_write_q;
        rd_data_d   = rd_valid_d ? rd_word : '0;
        rsp_valid_d = rd_valid_q;
        rsp_data_d  = rd_data_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
`else
    assign rsp_valid_o = 1'b0;
    assign rsp_data_o  = '0;
`endif

    // Output mapping
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SCALES; gi++) begin : g_scale
            assign a_o[gi]  = cst_out_q[0][gi];
            assign b_o[gi]  = cst_out_q[1][gi];
            assign w0_o[gi] = cst_out_q[2][gi];
            assign w1_o[gi] = cst_out_q[3][gi];
            assign w2_o[gi] = cst_out_q[4][gi];
        end
        for (gi = 0; gi < NUM_CAMERAS * 9; gi++) begin : g_coef
            assign bilinear_matrices_o[gi / 9][(gi % 9) / 3][gi % 3] = mat_out_q[gi / 9][gi % 9];
        end
    endgenerate

    assign pre_roi_boundaries_o  = pre_bnd_q;
    assign post_roi_boundaries_o = post_bnd_q;
    assign confidence_o          = conf_out_q;
    assign commit_pending_o      = pending_q;
    assign err_o                 = err_q;

endmodule

// File: tb/tb_cfg_regfile_multi.sv
// Directed testbench for cfg_regfile_multi with default parameters. Inputs
// change 1 ns after a rising edge; outputs are sampled at that same point.
// Read checks follow the CFG_READBACK_EN build setting.
module tb_cfg_regfile_multi;

    localparam int NC = 2;
    localparam int NS = 3;
    localparam int MW = 11;
    localparam int AW = 16;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                              rst, cmd_valid, cmd_write, frame_start;
    logic [AW-1:0]                     cmd_addr;
    logic [DW-1:0]                     cmd_data;
    logic                              rsp_valid;
    logic [DW-1:0]                     rsp_data;
    logic [NS-1:0][15:0]               a_o, b_o, w0_o, w1_o, w2_o;
    logic [NC-1:0][2:0][2:0][MW-1:0]   mats;
    logic [3:0][15:0]                  pre_roi, post_roi;
    logic [15:0]                       conf;
    logic                              pending, err;

    cfg_regfile_multi dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .cmd_valid_i           (cmd_valid),
        .cmd_write_i           (cmd_write),
        .cmd_addr_i            (cmd_addr),
        .cmd_data_i            (cmd_data),
        .frame_start_i         (frame_start),
        .rsp_valid_o           (rsp_valid),
        .rsp_data_o            (rsp_data),
        .a_o                   (a_o),
        .b_o                   (b_o),
        .w0_o                  (w0_o),
        .w1_o                  (w1_o),
        .w2_o                  (w2_o),
        .bilinear_matrices_o   (mats),
        .pre_roi_boundaries_o  (pre_roi),
        .post_roi_boundaries_o (post_roi),
        .confidence_o          (conf),
        .commit_pending_o      (pending),
        .err_o                 (err)
    );

    int tests = 0;
    int fails = 0;
    logic [NC-1:0][2:0][2:0][MW-1:0] exp_mat;
    logic [3:0][15:0] roi_dflt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = a;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = a;
        cmd_data  = '0;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_data = '0; frame_start = 1'b0;
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < 3; r++)
                for (int k = 0; k < 3; k++)
                    exp_mat[c][r][k] = (r == k) ? 11'h100 : 11'h000;
        roi_dflt = {16'd0, 16'd480, 16'd0, 16'd512};

        // Reset defaults
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();
        chk("rst_a", a_o, {NS{16'h3c00}});
        chk("rst_b", b_o, {NS{16'h3c00}});
        chk("rst_w2", w2_o, {NS{16'h3c00}});
        chk("rst_mat", mats, exp_mat);
        chk("rst_pre_roi", pre_roi, roi_dflt);
        chk("rst_post_roi", post_roi, roi_dflt);
        chk("rst_conf", conf, 16'h0000);
        chk("rst_err", err, 1'b0);
        chk("rst_pending", pending, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);

        // Stage ROI x, a matrix coefficient, confidence and W2, then commit
        wr(16'h0081, 32'h0000_0010);
        wr(16'h0025, 32'hABCD_E123);   // cam1 row1 col2, truncated to 11 bits
        wr(16'h0050, 32'h0001_BEEF);   // truncated to 16 bits
        wr(16'h00E2, 32'h0000_7777);
        wr(16'h00F0, 32'h0);
        tick();
        chk("arm_pending", pending, 1'b1);
        chk("arm_pre_roi_hold", pre_roi, roi_dflt);
        chk("arm_conf_hold", conf, 16'h0000);
        pulse();
        chk("commit_pending_clr", pending, 1'b0);
        chk("commit_conf_edge", conf, 16'h0000);
        tick();
        exp_mat[1][1][2] = 11'h123;
        chk("commit_mat", mats, exp_mat);
        chk("commit_conf", conf, 16'hBEEF);
        chk("commit_w2_2", w2_o[2], 16'h7777);
        chk("commit_roi_lag", pre_roi, roi_dflt);
        tick();
        chk("commit_pre_roi", pre_roi, {16'd0, 16'd480, 16'h0010, 16'h0210});
        chk("commit_post_roi", post_roi, roi_dflt);

        // Staged write without commit stays invisible
        wr(16'h00A1, 32'h0000_4000);
        tick();
        pulse();
        tick(); tick();
        chk("nocommit_a1", a_o[1], 16'h3c00);
        chk("nocommit_pending", pending, 1'b0);
        rd(16'h00A1);
        chk("rd_lat0", rsp_valid, 1'b0);
        tick();
        chk("rd_lat1", rsp_valid, 1'b0);
        tick();
`ifdef CFG_READBACK_EN
        chk("rd_valid", rsp_valid, 1'b1);
        chk("rd_data", rsp_data, 32'h0000_4000);
`else
        chk("rd_valid_off", rsp_valid, 1'b0);
        chk("rd_data_off", rsp_data, 32'h0);
`endif
        tick();
        chk("rd_done", rsp_valid, 1'b0);
        chk("rd_err", err, 1'b0);
`ifdef CFG_READBACK_EN
        rd(16'h00A0);
        rd(16'h00A1);
        tick();
        chk("stream0_valid", rsp_valid, 1'b1);
        chk("stream0_data", rsp_data, 32'h0000_3c00);
        tick();
        chk("stream1_valid", rsp_valid, 1'b1);
        chk("stream1_data", rsp_data, 32'h0000_4000);
`endif

        // Commit command in the same cycle as frame_start
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h00F0; frame_start = 1'b1;
        tick();
        cmd_valid = 1'b0; cmd_write = 1'b0; frame_start = 1'b0;
        chk("f0fs_pending_early", pending, 1'b0);
        tick();
        chk("f0fs_pending", pending, 1'b1);
        tick();
        chk("f0fs_a1_hold", a_o[1], 16'h3c00);
        pulse();
        chk("f0fs_pending_clr", pending, 1'b0);
        chk("f0fs_a1_edge", a_o[1], 16'h3c00);
        tick();
        chk("f0fs_a1", a_o[1], 16'h4000);

        // Error flag: unmapped camera, unmapped scale, clear
        wr(16'h0030, 32'h0000_0001);
        chk("err_early", err, 1'b0);
        tick();
        chk("err_cam", err, 1'b1);
        chk("err_mat_hold", mats, exp_mat);
        wr(16'h00F1, 32'h0);
        tick();
        chk("err_clr", err, 1'b0);
        wr(16'h00A3, 32'h0000_0005);
        tick();
        chk("err_scale", err, 1'b1);
        wr(16'h00F1, 32'h0);
        tick();
        chk("err_clr2", err, 1'b0);
        rd(16'h0030);
        tick();
`ifdef CFG_READBACK_EN
        chk("err_rd", err, 1'b1);
        tick();
        chk("err_rd_valid", rsp_valid, 1'b1);
        chk("err_rd_data", rsp_data, 32'h0);
        rd(16'h00F0);
        tick(); tick();
        chk("status_rd", rsp_data, 32'h0000_0002);
        wr(16'h00F1, 32'h0);
        tick();
`else
        chk("err_rd_off", err, 1'b0);
`endif

        // ROI wrap-around
        wr(16'h0080, 32'h0000_FFF0);
        wr(16'h00F0, 32'h0);
        tick();
        pulse();
        tick(); tick();
        chk("wrap_pre_roi", pre_roi, {16'hFFF0, 16'h01D0, 16'h0010, 16'h0210});
        chk("wrap_post_roi", post_roi, roi_dflt);

        // Reset mid-sequence: armed commit and in-flight write are dropped
        wr(16'h00F0, 32'h0);
        wr(16'h00A0, 32'h0000_1234);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < 3; r++)
                for (int k = 0; k < 3; k++)
                    exp_mat[c][r][k] = (r == k) ? 11'h100 : 11'h000;
        chk("mid_rst_pending", pending, 1'b0);
        chk("mid_rst_a", a_o, {NS{16'h3c00}});
        chk("mid_rst_mat", mats, exp_mat);
        chk("mid_rst_pre_roi", pre_roi, roi_dflt);
        chk("mid_rst_conf", conf, 16'h0000);
        chk("mid_rst_err", err, 1'b0);
        chk("mid_rst_rsp", rsp_valid, 1'b0);
        wr(16'h00F0, 32'h0);
        tick();
        pulse();
        tick(); tick();
        chk("post_rst_a", a_o, {NS{16'h3c00}});
        chk("post_rst_w2", w2_o, {NS{16'h3c00}});
        chk("post_rst_pre_roi", pre_roi, roi_dflt);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
